// File: rtl/matrix_add_pkg.sv
// Shared constants and packing helpers for the streaming matrix adder/subtractor.
package matrix_add_pkg;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

  // Bit offset of element 'elem' in lane 'lane' inside a flat operand or result bus.
  // The same formula covers A/B (width = IN_WIDTH) and S (width = IN_WIDTH+1).
  function automatic int elemOffset(input int lane, input int elem,
                                    input int vecLen, input int width);
    return (lane * vecLen + elem) * width;
  endfunction

endpackage

// File: rtl/matrix_addsub_stream_if.sv
// Handshake and data bundle between the operand buffers, the adder and the consumer.
interface matrix_addsub_stream_if #(
  parameter int IN_WIDTH = 16,
  parameter int VEC_LEN  = 12,
  parameter int LANES    = 2,
  parameter int SETS     = 5
);

  localparam int SET_W = (SETS > 1) ? $clog2(SETS) : 1;
  localparam int A_W   = LANES * VEC_LEN * IN_WIDTH;
  localparam int S_W   = LANES * VEC_LEN * (IN_WIDTH + 1);

  logic             enable;
  logic             in_valid;
  logic             in_ready;
  logic             mode;
  logic [A_W-1:0]   a_flat;
  logic [A_W-1:0]   b_flat;
  logic [SET_W-1:0] set_in_no;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [S_W-1:0]   s_flat;
  logic             early_out_valid;
  logic [SET_W-1:0] set_out_no;
  logic             out_last;
  logic             matrix_done;

  // The adder itself sits on this side.
  modport slave (
    input  enable, in_valid, mode, a_flat, b_flat, out_ready,
    output in_ready, set_in_no, in_last, out_valid, s_flat,
           early_out_valid, set_out_no, out_last, matrix_done
  );

  // Whoever feeds operands and drains results sits on this side.
  modport master (
    output enable, in_valid, mode, a_flat, b_flat, out_ready,
    input  in_ready, set_in_no, in_last, out_valid, s_flat,
           early_out_valid, set_out_no, out_last, matrix_done
  );

endinterface

// File: rtl/vector_addsub_lane.sv
// One lane of element-wise add/subtract: VEC_LEN signed elements, results one bit wider so nothing overflows.
module vector_addsub_lane
  import matrix_add_pkg::*;
#(
  parameter int IN_WIDTH = 16,
  parameter int VEC_LEN  = 12
) (
  input  logic                           mode,
  input  logic [VEC_LEN*IN_WIDTH-1:0]     aVec,
  input  logic [VEC_LEN*IN_WIDTH-1:0]     bVec,
  output logic [VEC_LEN*(IN_WIDTH+1)-1:0] sVec
);

  for (genvar e = 0; e < VEC_LEN; e++) begin : gElem
    localparam int A_OFF = elemOffset(0, e, VEC_LEN, IN_WIDTH);
    localparam int S_OFF = elemOffset(0, e, VEC_LEN, IN_WIDTH + 1);

    logic signed [IN_WIDTH:0] aExt;
    logic signed [IN_WIDTH:0] bExt;

    assign aExt = {aVec[A_OFF+IN_WIDTH-1], aVec[A_OFF +: IN_WIDTH]};
    assign bExt = {bVec[A_OFF+IN_WIDTH-1], bVec[A_OFF +: IN_WIDTH]};
    assign sVec[S_OFF +: IN_WIDTH+1] = (mode == MODE_SUB) ? (aExt - bExt) : (aExt + bExt);
  end

endmodule

// File: rtl/matrix_addsub_stream.sv
// Two-stage streaming matrix adder/subtractor with per-matrix set tracking.
// Stage 1 captures operands, stage 2 holds the exact sums; a stalled output freezes both.
module matrix_addsub_stream
  import matrix_add_pkg::*;
#(
  parameter int IN_WIDTH = 16,
  parameter int VEC_LEN  = 12,
  parameter int LANES    = 2,
  parameter int SETS     = 5,
  parameter int SET_W    = (SETS > 1) ? $clog2(SETS) : 1
) (
  input logic                    clk,
  input logic                    reset,
  matrix_addsub_stream_if.slave  bus
);

  localparam int LANE_A_W = VEC_LEN * IN_WIDTH;
  localparam int LANE_S_W = VEC_LEN * (IN_WIDTH + 1);
  localparam int A_W      = LANES * LANE_A_W;
  localparam int S_W      = LANES * LANE_S_W;
  localparam logic [SET_W-1:0] LAST_SET = SET_W'(SETS - 1);

  logic             stall;
  logic             inXfer;
  logic             outXfer;
  logic [SET_W-1:0] setInNo;
  logic [SET_W-1:0] setInNext;
  logic             s1Valid;
  logic [A_W-1:0]   s1A;
  logic [A_W-1:0]   s1B;
  logic             s1Mode;
  logic [SET_W-1:0] s1Idx;
  logic [S_W-1:0]   sumNext;
  logic             outValid;
  logic [S_W-1:0]   sReg;
  logic [SET_W-1:0] setOutNo;
  logic             outLast;
  logic             matrixDone;

  // No skid buffer: the input is refused exactly while an unaccepted result is waiting.
  assign stall   = outValid && !bus.out_ready;
  assign inXfer  = bus.enable && bus.in_valid && !stall;
  assign outXfer = bus.enable && outValid && bus.out_ready;

  assign setInNext = (setInNo == LAST_SET) ? '0 : setInNo + 1'b1;
  assign outLast   = (setOutNo == LAST_SET);

  assign bus.in_ready        = !stall;
  assign bus.set_in_no       = setInNo;
  assign bus.in_last         = (setInNo == LAST_SET);
  assign bus.out_valid       = outValid;
  assign bus.s_flat          = sReg;
  assign bus.early_out_valid = s1Valid;
  assign bus.set_out_no      = setOutNo;
  assign bus.out_last        = outLast;
  assign bus.matrix_done     = matrixDone;

  // The arithmetic reads stage-1 registers so the sum lands in stage 2 one edge later.
  for (genvar l = 0; l < LANES; l++) begin : gLane
    localparam int A_OFF = elemOffset(l, 0, VEC_LEN, IN_WIDTH);
    localparam int S_OFF = elemOffset(l, 0, VEC_LEN, IN_WIDTH + 1);

    vector_addsub_lane #(
      .IN_WIDTH (IN_WIDTH),
      .VEC_LEN  (VEC_LEN)
    ) uLane (
      .mode (s1Mode),
      .aVec (s1A[A_OFF +: LANE_A_W]),
      .bVec (s1B[A_OFF +: LANE_A_W]),
      .sVec (sumNext[S_OFF +: LANE_S_W])
    );
  end

  // Stage 1: capture the accepted beat with the set index it was accepted under.
  always_ff @(posedge clk) begin
    if (reset) begin
      setInNo <= '0;
      s1Valid <= 1'b0;
      s1A     <= '0;
      s1B     <= '0;
      s1Mode  <= MODE_ADD;
      s1Idx   <= '0;
    end else if (bus.enable && !stall) begin
      s1Valid <= inXfer;
      if (inXfer) begin
        s1A     <= bus.a_flat;
        s1B     <= bus.b_flat;
        s1Mode  <= bus.mode;
        s1Idx   <= setInNo;
        setInNo <= setInNext;
      end
    end
  end

  // Stage 2: register the result together with its set index so the label always matches the data.
  always_ff @(posedge clk) begin
    if (reset) begin
      outValid <= 1'b0;
      sReg     <= '0;
      setOutNo <= '0;
    end else if (bus.enable && !stall) begin
      outValid <= s1Valid;
      sReg     <= sumNext;
      setOutNo <= s1Idx;
    end
  end

  // One-cycle completion pulse after the last set of a matrix leaves the block.
  always_ff @(posedge clk) begin
    if (reset) begin
      matrixDone <= 1'b0;
    end else begin
      matrixDone <= outXfer && outLast;
    end
  end

endmodule

// File: tb/tb_matrix_addsub_stream.sv
// Bench for matrix_addsub_stream: a default instance driven by directed and random steps
// against a cycle-level reference, plus a SETS=1 / LANES=4 / VEC_LEN=3 instance against a scoreboard.
module tb_matrix_addsub_stream;

  localparam int IW   = 16;
  localparam int VL   = 12;
  localparam int LN   = 2;
  localparam int ST   = 5;
  localparam int AW   = LN * VL * IW;
  localparam int SW   = LN * VL * (IW + 1);
  localparam int B_VL = 3;
  localparam int B_LN = 4;
  localparam int B_ST = 1;
  localparam int BAW  = B_LN * B_VL * IW;
  localparam int BSW  = B_LN * B_VL * (IW + 1);

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  matrix_addsub_stream_if #(.IN_WIDTH(IW), .VEC_LEN(VL), .LANES(LN), .SETS(ST)) busA ();
  matrix_addsub_stream_if #(.IN_WIDTH(IW), .VEC_LEN(B_VL), .LANES(B_LN), .SETS(B_ST)) busB ();

  matrix_addsub_stream #(.IN_WIDTH(IW), .VEC_LEN(VL), .LANES(LN), .SETS(ST)) dutA (
    .clk   (clk),
    .reset (reset),
    .bus   (busA)
  );

  matrix_addsub_stream #(.IN_WIDTH(IW), .VEC_LEN(B_VL), .LANES(B_LN), .SETS(B_ST)) dutB (
    .clk   (clk),
    .reset (reset),
    .bus   (busB)
  );

  int testsRun    = 0;
  int testsFailed = 0;

  typedef struct {
    bit            v;
    logic [SW-1:0] s;
    int            idx;
  } stageT;

  typedef struct {
    int             outEdge;
    logic [BSW-1:0] s;
  } bExpT;

  stageT mS1;
  stageT mOut;
  int    mSetIn;
  bit    mDone;

  // Element-wise exact sum/difference of flat buses, using plain integer arithmetic.
  function automatic logic [511:0] refSum(input logic [511:0] a, input logic [511:0] b,
                                          input bit sub, input int lanes, input int vlen);
    logic [511:0] res;
    int av;
    int bv;
    int rv;
    res = '0;
    for (int i = 0; i < lanes * vlen; i++) begin
      av = 32'(signed'(a[i*IW +: IW]));
      bv = 32'(signed'(b[i*IW +: IW]));
      rv = sub ? (av - bv) : (av + bv);
      res[i*(IW+1) +: IW+1] = rv[IW:0];
    end
    return res;
  endfunction

  function automatic logic [511:0] randFlat();
    logic [511:0] r;
    for (int i = 0; i < 16; i++) r[i*32 +: 32] = $urandom();
    return r;
  endfunction

  // Lane 0 elements all v0, lane 1 elements all v1.
  function automatic logic [AW-1:0] fillA(input int v0, input int v1);
    logic [AW-1:0] r;
    for (int e = 0; e < VL; e++) begin
      r[e*IW +: IW]      = v0[IW-1:0];
      r[(VL+e)*IW +: IW] = v1[IW-1:0];
    end
    return r;
  endfunction

  task automatic checkOutput(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    testsRun++;
    assert (obs === exp) else begin
      testsFailed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference for one clock edge of the default instance, given the inputs presented before it.
  task automatic modelStep(input bit inV, input bit md, input logic [AW-1:0] a,
                           input logic [AW-1:0] b, input bit oRdy, input bit en, input bit rst);
    bit stallNow;
    if (rst) begin
      mS1    = '{v: 1'b0, s: '0, idx: 0};
      mOut   = mS1;
      mSetIn = 0;
      mDone  = 1'b0;
    end else if (en) begin
      stallNow = mOut.v && !oRdy;
      mDone    = mOut.v && oRdy && (mOut.idx == ST - 1);
      if (!stallNow) begin
        mOut  = mS1;
        mS1.v = inV;
        if (inV) begin
          mS1.s   = SW'(refSum(512'(a), 512'(b), md, LN, VL));
          mS1.idx = mSetIn;
          mSetIn  = (mSetIn + 1) % ST;
        end
      end
    end else begin
      mDone = 1'b0;
    end
  endtask

  // One cycle on the default instance: drive, check combinational outputs, clock, check registers.
  task automatic applyStimulus(input bit inV, input bit md, input logic [AW-1:0] a,
                               input logic [AW-1:0] b, input bit oRdy, input bit en, input bit rst);
    busA.in_valid  = inV;
    busA.mode      = md;
    busA.a_flat    = a;
    busA.b_flat    = b;
    busA.out_ready = oRdy;
    busA.enable    = en;
    reset          = rst;
    #1;
    checkOutput("inReady", 512'(busA.in_ready), 512'(!(mOut.v && !oRdy)));
    checkOutput("inLast", 512'(busA.in_last), 512'(mSetIn == ST - 1));
    checkOutput("outLast", 512'(busA.out_last), 512'(mOut.idx == ST - 1));
    modelStep(inV, md, a, b, oRdy, en, rst);
    @(posedge clk);
    #1;
    checkOutput("outValid", 512'(busA.out_valid), 512'(mOut.v));
    checkOutput("earlyOutValid", 512'(busA.early_out_valid), 512'(mS1.v));
    checkOutput("setInNo", 512'(busA.set_in_no), 512'(mSetIn));
    checkOutput("setOutNo", 512'(busA.set_out_no), 512'(mOut.idx));
    checkOutput("matrixDone", 512'(busA.matrix_done), 512'(mDone));
    if (mOut.v) checkOutput("sFlat", 512'(busA.s_flat), 512'(mOut.s));
  endtask

  task automatic idleA(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, '0, '0, 1'b1, 1'b1, 1'b0);
  endtask

  task automatic beatA(input bit md, input logic [AW-1:0] a, input logic [AW-1:0] b);
    applyStimulus(1'b1, md, a, b, 1'b1, 1'b1, 1'b0);
  endtask

  initial begin
    bExpT bq[$];
    bExpT bItem;
    int   edgeNo;
    int   accepted;
    int   guard;
    bit   prevOutXfer;
    bit   expV;
    bit   inV;
    bit   md;
    logic [BAW-1:0] ba;
    logic [BAW-1:0] bb;

    // Unchecked power-up reset so both instances leave the unknown state.
    reset          = 1'b1;
    busA.enable    = 1'b1;
    busA.in_valid  = 1'b0;
    busA.mode      = 1'b0;
    busA.a_flat    = '0;
    busA.b_flat    = '0;
    busA.out_ready = 1'b1;
    busB.enable    = 1'b1;
    busB.in_valid  = 1'b0;
    busB.mode      = 1'b0;
    busB.a_flat    = '0;
    busB.b_flat    = '0;
    busB.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    modelStep(1'b0, 1'b0, '0, '0, 1'b1, 1'b1, 1'b1);

    // Reset values.
    applyStimulus(1'b0, 1'b0, '0, '0, 1'b1, 1'b1, 1'b1);
    checkOutput("resetSFlat", 512'(busA.s_flat), 512'(0));

    // One full matrix of 1+2.
    for (int k = 0; k < 5; k++) beatA(1'b0, fillA(1, 1), fillA(2, 2));
    idleA(3);

    // Extremes; lane 1 carries different values to expose cross-talk.
    beatA(1'b0, fillA(32767, -5), fillA(32767, 100));
    beatA(1'b1, fillA(-32768, 7), fillA(32767, -9));
    checkOutput("extAddLane0", 512'(busA.s_flat[16:0]), 512'(17'h0FFFE));
    checkOutput("extAddLane1", 512'(busA.s_flat[204 +: 17]), 512'(17'd95));
    idleA(1);
    checkOutput("extSubLane0", 512'(busA.s_flat[16:0]), 512'(17'h10001));
    checkOutput("extSubLane1", 512'(busA.s_flat[204 +: 17]), 512'(17'd16));
    idleA(2);

    // Downstream back-pressure for 3 cycles with input still offered.
    beatA(1'b0, AW'(randFlat()), AW'(randFlat()));
    beatA(1'b1, AW'(randFlat()), AW'(randFlat()));
    for (int k = 0; k < 3; k++)
      applyStimulus(1'b1, 1'b0, AW'(randFlat()), AW'(randFlat()), 1'b0, 1'b1, 1'b0);
    beatA(1'b0, AW'(randFlat()), AW'(randFlat()));
    beatA(1'b1, AW'(randFlat()), AW'(randFlat()));
    idleA(3);

    // Clock enable dropped mid-matrix after set 2.
    applyStimulus(1'b0, 1'b0, '0, '0, 1'b1, 1'b1, 1'b1);
    for (int k = 0; k < 3; k++) beatA(1'b0, AW'(randFlat()), AW'(randFlat()));
    for (int k = 0; k < 2; k++)
      applyStimulus(1'b1, 1'b1, AW'(randFlat()), AW'(randFlat()), 1'b1, 1'b0, 1'b0);
    checkOutput("enHoldSetIn", 512'(busA.set_in_no), 512'(3));
    for (int k = 0; k < 2; k++) beatA(1'b1, AW'(randFlat()), AW'(randFlat()));
    idleA(3);

    // Reset while sets 1 and 2 are in flight, then a clean matrix.
    for (int k = 0; k < 3; k++) beatA(1'b0, AW'(randFlat()), AW'(randFlat()));
    applyStimulus(1'b0, 1'b0, '0, '0, 1'b1, 1'b1, 1'b1);
    checkOutput("midResetOutValid", 512'(busA.out_valid), 512'(0));
    for (int k = 0; k < 5; k++) beatA(1'b0, AW'(randFlat()), AW'(randFlat()));
    idleA(3);

    // Random traffic with back-pressure and enable gaps.
    for (int k = 0; k < 200; k++)
      applyStimulus($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
                    AW'(randFlat()), AW'(randFlat()),
                    $urandom_range(0, 3) != 0, $urandom_range(0, 9) != 0, 1'b0);
    idleA(3);

    // SETS=1 instance: 100 random beats against a latency-stamped scoreboard.
    busA.in_valid = 1'b0;
    edgeNo      = 0;
    accepted    = 0;
    guard       = 0;
    prevOutXfer = 1'b0;
    while ((accepted < 100 || bq.size() > 0) && guard < 2000) begin
      guard++;
      inV = (accepted < 100) && ($urandom_range(0, 4) != 0);
      md  = 1'($urandom_range(0, 1));
      ba  = BAW'(randFlat());
      bb  = BAW'(randFlat());
      busB.in_valid = inV;
      busB.mode     = md;
      busB.a_flat   = ba;
      busB.b_flat   = bb;
      #1;
      checkOutput("bInReady", 512'(busB.in_ready), 512'(1));
      checkOutput("bInLast", 512'(busB.in_last), 512'(1));
      if (inV) begin
        bItem.outEdge = edgeNo + 2;
        bItem.s       = BSW'(refSum(512'(ba), 512'(bb), md, B_LN, B_VL));
        bq.push_back(bItem);
        accepted++;
      end
      @(posedge clk);
      #1;
      edgeNo++;
      expV = (bq.size() > 0) && (bq[0].outEdge == edgeNo);
      checkOutput("bOutValid", 512'(busB.out_valid), 512'(expV));
      checkOutput("bMatrixDone", 512'(busB.matrix_done), 512'(prevOutXfer));
      checkOutput("bSetInNo", 512'(busB.set_in_no), 512'(0));
      if (expV) begin
        bItem = bq.pop_front();
        checkOutput("bSFlat", 512'(busB.s_flat), 512'(bItem.s));
        checkOutput("bSetOutNo", 512'(busB.set_out_no), 512'(0));
        checkOutput("bOutLast", 512'(busB.out_last), 512'(1));
      end
      prevOutXfer = expV;
    end
    busB.in_valid = 1'b0;
    checkOutput("bAccepted", 512'(accepted), 512'(100));
    checkOutput("bDrained", 512'(bq.size()), 512'(0));

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/matrix_addsub_stream.md
Name: matrix_addsub_stream

Overview:
- Parametrised streaming matrix adder/subtractor.
- Accepts LANES vectors of VEC_LEN signed elements per beat; one matrix is SETS beats.
- Produces exact (IN_WIDTH+1)-bit sums or differences through a 2-stage pipeline with valid/ready handshakes on both sides.
- Tracks per-matrix vector-set indices on the input and output sides and flags the last set of each matrix.
- Sits between the matrix operand buffers and downstream LinearAlgebra layers.

Parameters:
- IN_WIDTH, 16, operand element width in bits (two's complement).
- VEC_LEN, 12, elements per vector.
- LANES, 2, vectors processed in parallel per beat.
- SETS, 5, beats per matrix (≥1); the matrix is VEC_LEN x (LANES*SETS).
- SET_W, $clog2(SETS) (min 1), width of the set counters.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  global clock enable; when low, all state holds.
- in_valid  in  1  an operand beat is present.
- in_ready  out  1  the block accepts a beat this cycle.
- mode  in  1  0 = A+B, 1 = A−B; sampled with the beat.
- a_flat  in  LANES*VEC_LEN*IN_WIDTH  operand A; element e of lane l is at bits [(l*VEC_LEN+e)*IN_WIDTH +: IN_WIDTH].
- b_flat  in  LANES*VEC_LEN*IN_WIDTH  operand B; same packing as a_flat.
- set_in_no  out  SET_W  index of the next set to be accepted.
- in_last  out  1  set_in_no == SETS-1.
- out_valid  out  1  a result beat is present.
- out_ready  in  1  downstream accepts the result.
- s_flat  out  LANES*VEC_LEN*(IN_WIDTH+1)  result; packing as a_flat with IN_WIDTH+1 per element.
- early_out_valid  out  1  stage-1 holds a valid beat (one cycle ahead of out_valid when not stalled).
- set_out_no  out  SET_W  set index of the beat on s_flat.
- out_last  out  1  the beat on s_flat is set SETS-1.
- matrix_done  out  1  one-cycle pulse when the last set's output transfers.

Behaviour:
- Reset values: set_in_no=0, set_out_no=0, out_valid=0, early_out_valid=0, matrix_done=0, s_flat=0, and stage-1 valid=0.
- Input transfer occurs when enable && in_valid && in_ready. Output transfer occurs when enable && out_valid && out_ready.
- Stall condition: stall = out_valid && !out_ready.
  - in_ready = !stall.
  - On stall, both pipeline stages hold their contents.
  - in_ready is combinational from out_valid/out_ready; there is no skid buffer.
- Stage 1 (on input transfer):
  - Registers a_flat, b_flat, mode and the current set_in_no.
  - Sets valid=1. A non-stalled cycle without input transfer clears valid.
- Stage 2 (when not stalled):
  - Loads stage-1 contents.
  - Computes each element as sext(a)+sext(b) or sext(a)−sext(b) at IN_WIDTH+1 bits. The result is exact and never overflows; for example, −32768−32767 = −65535.
  - out_valid <= stage-1 valid; set_out_no <= the registered index.
- Latency: accepted beat to out_valid is 2 cycles with no stalls. Throughput is 1 beat/cycle.
- Set counters:
  - set_in_no increments on each input transfer and wraps SETS-1→0.
  - set_out_no travels with the data, so it always labels the beat on s_flat.
- out_last is combinational from set_out_no.
- matrix_done is registered: asserted the cycle after an output transfer with out_last=1, for one cycle.
- enable=0: no transfers, counters hold, outputs hold, matrix_done is forced 0 next cycle.
- Reset mid-matrix discards in-flight beats, and both counters return to 0 on the next edge. Reset has priority over enable.
- Simultaneous output transfer and a new stage-1 beat advance in the same cycle with no bubble.
- SETS=1: set_in_no stays 0, in_last=1 always, and every output transfer pulses matrix_done.

Decomposition:
- Package matrix_add_pkg:
  - Localparams MODE_ADD=1'b0 and MODE_SUB=1'b1.
  - An element-slice offset function shared by A/B/S packing.
- Sub-module vector_addsub_lane (IN_WIDTH, VEC_LEN):
  - Combinational VEC_LEN-element sign-extending add/sub with a mode input.
  - Instantiated LANES times in stage 2; the top holds the handshake, pipeline and counters.

Test Plan:
- Reset, then 5 beats with all A=1, B=2, mode=0, out_ready=1 → s=3 everywhere, first out_valid 2 cycles after first accept, set_out_no 0..4, matrix_done pulses once after set 4.
- Extremes (IN_WIDTH=16): A=32767, B=32767, add → 65534. A=−32768, B=32767, mode=1 → −65535. Lane 1 carries distinct values → no lane cross-talk.
- Hold out_ready=0 for 3 cycles with in_valid=1 → in_ready=0 from the cycle out_valid rises, no beat lost or duplicated, s_flat and set_out_no stable.
- Toggle enable low for 2 cycles mid-matrix after set 2 → counters freeze at their values, and the matrix completes with correct indices 3, 4 afterwards.
- Assert reset while sets 1 and 2 are in flight → out_valid=0 and counters=0 next cycle, and a new matrix starts cleanly at set 0.
- SETS=1, LANES=4, VEC_LEN=3 instance, random operands for 100 beats vs. a scoreboard → exact match, and matrix_done on every output.
